bus_regfile: RTL and testbench

Parametrised successor to the single 8-bit bus register. It holds DEPTH registers of WIDTH bits behind one shared tristate bus. Each clock edge the register file can load from the bus or increment/decrement the addressed register. Any register can be driven back onto the bus. It serves as the CPU's general-purpose register bank and as the pointer/counter registers (SP, index), and replaces discrete register instances on the bus.

---
 rtl/bus_regfile.sv | 95 +++++++++
 tb/tb_bus_regfile.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/bus_regfile.sv
// rtl/bus_regfile.sv - DEPTH x WIDTH register file behind one shared tristate bus
// Ports:
//   clk       system clock, state updates on rising edge
//   clear_n   asynchronous active-low clear; release is synchronised internally
//   load      capture bus into reg[addr_w]
//   inc/dec   increment / decrement reg[addr_w] modulo 2^WIDTH
//   addr_w    write/modify target register
//   enable    drive reg[addr_r] onto bus
//   addr_r    read/drive source register
//   bus       shared tristate bus
//   data_out  reg[addr_r], always driven (0 for an out-of-range addr_r)
//   zero      data_out == 0
//   carry     wrap flag from the last inc/dec
//   addr_err  sticky out-of-range address flag
module bus_regfile #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             load,
  input  logic             inc,
  input  logic             dec,
  input  logic [AW-1:0]    addr_w,
  input  logic             enable,
  input  logic [AW-1:0]    addr_r,
  inout  wire  [WIDTH-1:0] bus,
  output logic [WIDTH-1:0] data_out,
  output logic             zero,
  output logic             carry,
  output logic             addr_err
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] regs [DEPTH];
  logic             rel_q0;
  logic             rel_q1;
  logic             w_ok;
  logic             r_ok;
  logic             write_op;
  logic [WIDTH-1:0] rd_data;
  logic [WIDTH-1:0] cur_w;

  // Addresses are widened before comparing so a non-power-of-two DEPTH
  // can be range checked without a constant-folded compare.
  assign w_ok     = 32'(addr_w) < 32'(DEPTH);
  assign r_ok     = 32'(addr_r) < 32'(DEPTH);
  assign write_op = load | inc | dec;

  assign cur_w    = w_ok ? regs[addr_w] : '0;
  assign rd_data  = r_ok ? regs[addr_r] : '0;
  assign data_out = rd_data;
  assign zero     = (rd_data == '0);
  assign bus      = enable ? rd_data : {WIDTH{1'bz}};

  // Two-flop release of clear_n. The first stage samples on the falling
  // edge so that, for a release between edges, the write side is live on
  // the second rising edge after clear_n rises.
  always_ff @(negedge clk or negedge clear_n) begin
    if (!clear_n) rel_q0 <= 1'b0;
    else          rel_q0 <= 1'b1;
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) rel_q1 <= 1'b0;
    else          rel_q1 <= rel_q0;
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      carry    <= 1'b0;
      addr_err <= 1'b0;
    end else if (rel_q1) begin
      if ((write_op && !w_ok) || !r_ok) addr_err <= 1'b1;
      if (w_ok) begin
        if (load) begin
          regs[addr_w] <= bus;
          carry        <= 1'b0;
        end else if (inc && !dec) begin
          regs[addr_w] <= cur_w + ONE;
          carry        <= &cur_w;
        end else if (dec && !inc) begin
          regs[addr_w] <= cur_w - ONE;
          carry        <= ~|cur_w;
        end else if (inc && dec) begin
          carry <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_bus_regfile.sv
// tb/tb_bus_regfile.sv - randomized self-checking bench for bus_regfile (DEPTH 4 and DEPTH 3)
module tb_bus_regfile;

  logic       clk = 1'b0;
  logic       clear_n;
  logic       load, inc, dec, enable;
  logic [1:0] addr_w, addr_r;
  logic       tb_drv;
  logic [7:0] tb_val;

  wire  [7:0] bus_a, bus_b;
  logic [7:0] do_a, do_b;
  logic       zero_a, zero_b, carry_a, carry_b, err_a, err_b;

  int errors = 0;
  int checks = 0;

  // Released bus reads all ones through the pullups.
  pullup (bus_a);
  pullup (bus_b);
  assign bus_a = tb_drv ? tb_val : 8'bz;
  assign bus_b = tb_drv ? tb_val : 8'bz;

  always #5 clk = ~clk;

  bus_regfile #(.WIDTH(8), .DEPTH(4)) dut_a (
    .clk(clk), .clear_n(clear_n), .load(load), .inc(inc), .dec(dec),
    .addr_w(addr_w), .enable(enable), .addr_r(addr_r), .bus(bus_a),
    .data_out(do_a), .zero(zero_a), .carry(carry_a), .addr_err(err_a)
  );

  bus_regfile #(.WIDTH(8), .DEPTH(3)) dut_b (
    .clk(clk), .clear_n(clear_n), .load(load), .inc(inc), .dec(dec),
    .addr_w(addr_w), .enable(enable), .addr_r(addr_r), .bus(bus_b),
    .data_out(do_b), .zero(zero_b), .carry(carry_b), .addr_err(err_b)
  );

  // Reference model: index 0 models DEPTH=4, index 1 models DEPTH=3.
  int m_reg [2][4];
  int m_carry [2];
  int m_err [2];
  int depth_of [2] = '{4, 3};
  int rel_cnt = 0;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int dout_of(input int d);
    return (d == 0) ? int'(do_a) : int'(do_b);
  endfunction
  function automatic int zero_of(input int d);
    return (d == 0) ? int'(zero_a) : int'(zero_b);
  endfunction
  function automatic int carry_of(input int d);
    return (d == 0) ? int'(carry_a) : int'(carry_b);
  endfunction
  function automatic int err_of(input int d);
    return (d == 0) ? int'(err_a) : int'(err_b);
  endfunction
  function automatic int bus_of(input int d);
    return (d == 0) ? int'(bus_a) : int'(bus_b);
  endfunction

  function automatic int m_read(input int d, input int ar);
    return (ar < depth_of[d]) ? m_reg[d][ar] : 0;
  endfunction

  task automatic model_clear();
    for (int d = 0; d < 2; d++) begin
      for (int r = 0; r < 4; r++) m_reg[d][r] = 0;
      m_carry[d] = 0;
      m_err[d]   = 0;
    end
    rel_cnt = 0;
  endtask

  // One rising edge of the specified behaviour, applied to both models.
  task automatic model_edge(input bit ld, input bit in, input bit de, input int aw,
                            input bit en, input int ar, input int val);
    int bv;
    int cur;
    if (!clear_n) return;
    if (rel_cnt < 2) rel_cnt++;
    if (rel_cnt < 2) return;
    for (int d = 0; d < 2; d++) begin
      bv = en ? m_read(d, ar) : val;
      if ((ld || in || de) && aw >= depth_of[d]) m_err[d] = 1;
      if (ar >= depth_of[d]) m_err[d] = 1;
      if (aw < depth_of[d]) begin
        cur = m_reg[d][aw];
        if (ld) begin
          m_reg[d][aw] = bv;
          m_carry[d]   = 0;
        end else if (in && !de) begin
          m_reg[d][aw] = (cur + 1) % 256;
          m_carry[d]   = (cur == 255) ? 1 : 0;
        end else if (de && !in) begin
          m_reg[d][aw] = (cur + 255) % 256;
          m_carry[d]   = (cur == 0) ? 1 : 0;
        end else if (in && de) begin
          m_carry[d] = 0;
        end
      end
    end
  endtask

  task automatic check_all(input bit en, input int ar, input bit drv, input int val);
    int exp_rd;
    int exp_bus;
    for (int d = 0; d < 2; d++) begin
      exp_rd  = m_read(d, ar);
      exp_bus = en ? exp_rd : (drv ? val : 255);
      check($sformatf("dout%0d", d),  dout_of(d),  exp_rd);
      check($sformatf("zero%0d", d),  zero_of(d),  (exp_rd == 0) ? 1 : 0);
      check($sformatf("carry%0d", d), carry_of(d), m_carry[d]);
      check($sformatf("err%0d", d),   err_of(d),   m_err[d]);
      check($sformatf("bus%0d", d),   bus_of(d),   exp_bus);
    end
  endtask

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic cyc(input bit ld, input bit in, input bit de, input int aw,
                     input bit en, input int ar, input bit drv, input int val);
    load = ld; inc = in; dec = de; addr_w = aw[1:0];
    enable = en; addr_r = ar[1:0]; tb_drv = drv; tb_val = val[7:0];
    @(posedge clk);
    model_edge(ld, in, de, aw, en, ar, val);
    #2;
    check_all(en, ar, drv, val);
    @(negedge clk);
  endtask

  // Asynchronous clear away from the clock edge, checked immediately.
  task automatic reset_and_check();
    #2;
    load = 0; inc = 0; dec = 0; tb_drv = 0; enable = 0;
    clear_n = 1'b0;
    model_clear();
    for (int ar = 0; ar < 4; ar++) begin
      addr_r = ar[1:0];
      enable = 0;
      #1;
      check_all(1'b0, ar, 1'b0, 0);
      enable = 1;
      #1;
      check("bus0_rst", int'(bus_a), 0);
      check("bus1_rst", int'(bus_b), 0);
    end
    enable = 0;
    @(posedge clk);
    #1 clear_n = 1'b1;
    @(negedge clk);
  endtask

  function automatic int pick_val();
    case ($urandom_range(0, 3))
      0:       return 0;
      1:       return 255;
      2:       return 254;
      default: return int'($urandom_range(0, 255));
    endcase
  endfunction

  initial begin
    clear_n = 1'b0;
    load = 0; inc = 0; dec = 0; enable = 0;
    addr_w = 0; addr_r = 0; tb_drv = 0; tb_val = 0;
    model_clear();
    repeat (2) @(negedge clk);
    reset_and_check();

    // First edge after release is ignored, second is honoured.
    cyc(1, 0, 0, 2, 0, 2, 1, 8'hFE);
    cyc(1, 0, 0, 2, 0, 2, 1, 8'hFE);
    cyc(0, 0, 0, 0, 1, 2, 0, 0);

    // inc wrap and carry
    cyc(1, 0, 0, 1, 0, 1, 1, 8'hFF);
    cyc(0, 1, 0, 1, 0, 1, 0, 0);
    cyc(0, 1, 0, 1, 0, 1, 0, 0);

    // dec wrap, then inc+dec no-op clears carry
    cyc(1, 0, 0, 0, 0, 0, 1, 8'h00);
    cyc(0, 0, 1, 0, 0, 0, 0, 0);
    cyc(0, 1, 1, 0, 0, 0, 0, 0);

    // register-to-register move over the bus, then release
    cyc(1, 0, 0, 3, 0, 3, 1, 8'h69);
    cyc(1, 0, 0, 0, 1, 3, 0, 0);
    cyc(0, 0, 0, 0, 0, 3, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);

    // load with enable on the same address keeps the contents
    cyc(1, 0, 0, 2, 1, 2, 0, 0);

    reset_and_check();

    // write to address 3: out of range for the DEPTH=3 instance only
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 3, 0, 0, 1, 8'h5A);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0, i % 3, 0, 0);

    for (int n = 0; n < 400; n++) begin
      bit ld, in, de, en;
      int aw, ar;
      if (n == 200) reset_and_check();
      ld = ($urandom_range(0, 3) == 0);
      in = $urandom_range(0, 1) == 1;
      de = $urandom_range(0, 1) == 1;
      en = ($urandom_range(0, 2) == 0);
      aw = int'($urandom_range(0, 3));
      ar = int'($urandom_range(0, 3));
      cyc(ld, in, de, aw, en, ar, ld && !en, pick_val());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
